bus_arbiter: RTL

//  Shares one single-port 32-bit memory bus between instruction fetch (IF) and the MEM stage
//  (load/store). Sits between cpu's pc_reg/if_id fetch path, memory, and the external bus;

---
 rtl/bus_arbiter_pkg.sv | 50 +++++
 rtl/bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared types and helpers for the instruction-fetch / load-store bus
//   arbiter. Holds the arbiter state encoding, the registered bus command
//   record, and the bus widths that the cpu core uses for register data and
//   instruction addresses.
// ----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int REG_BUS_W   = 32;
    localparam int INST_ADDR_W = 32;
    localparam int SEL_W       = 4;
    localparam int TMO_W       = 8;

    // Arbiter states: idle/arbitrating, fetch in flight, load/store in
    // flight, and a flushed fetch whose bus cycle still has to finish.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_ACC   = 2'd1,
        ARB_MEM_ACC  = 2'd2,
        ARB_IF_DRAIN = 2'd3
    } arb_state_e;

    // Everything the bus sees for one access, registered at grant time and
    // held stable until the access finishes.
    typedef struct packed {
        logic                 we;
        logic [SEL_W-1:0]     sel;
        logic [REG_BUS_W-1:0] addr;
        logic [REG_BUS_W-1:0] wdata;
    } bus_cmd_t;

    // A fetch is always a full-word read.
    function automatic bus_cmd_t fetchCmd(input logic [INST_ADDR_W-1:0] addr);
        bus_cmd_t cmd;
        cmd.we    = 1'b0;
        cmd.sel   = {SEL_W{1'b1}};
        cmd.addr  = addr;
        cmd.wdata = '0;
        return cmd;
    endfunction

    // Stores return zero on the load-data path so a stale bus value never
    // reaches the register file.
    function automatic logic [REG_BUS_W-1:0] loadData(input logic we,
                                                      input logic [REG_BUS_W-1:0] rdata);
        return we ? '0 : rdata;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Shares one single-port 32-bit memory bus between instruction fetch (IF)
//   and the MEM stage (load/store). MEM, the older instruction, has priority;
//   after MAX_MEM_BURST consecutive MEM grants with a fetch waiting, the next
//   grant goes to IF. Flushed fetches are drained without an ack, and an
//   access with no bus_ack after TIMEOUT bus cycles is aborted with bus_err.
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   if_req/if_addr/flush_in      fetch request side, flush discards fetch
//   if_rdata/if_ack              fetched word with one-cycle completion pulse
//   mem_req/we/sel/addr/wdata    load/store request side
//   mem_rdata/mem_ack            load data with one-cycle completion pulse
//   bus_req/we/sel/addr/wdata    registered bus command
//   bus_rdata/bus_ack            bus response
//   bus_err                      one-cycle pulse on an access timeout
//   stall_req_if/stall_req_mem   combinational stall requests towards ctrl
// ----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_MEM_BURST = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [INST_ADDR_W-1:0] if_addr,
    input  logic                   flush_in,
    output logic [REG_BUS_W-1:0]   if_rdata,
    output logic                   if_ack,

    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [SEL_W-1:0]       mem_sel,
    input  logic [REG_BUS_W-1:0]   mem_addr,
    input  logic [REG_BUS_W-1:0]   mem_wdata,
    output logic [REG_BUS_W-1:0]   mem_rdata,
    output logic                   mem_ack,

    output logic                   bus_req,
    output logic                   bus_we,
    output logic [SEL_W-1:0]       bus_sel,
    output logic [REG_BUS_W-1:0]   bus_addr,
    output logic [REG_BUS_W-1:0]   bus_wdata,
    input  logic [REG_BUS_W-1:0]   bus_rdata,
    input  logic                   bus_ack,
    output logic                   bus_err,

    output logic                   stall_req_if,
    output logic                   stall_req_mem
);

    localparam int BURST_W = (MAX_MEM_BURST < 1) ? 1 : $clog2(MAX_MEM_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_MEM_BURST);
    // The counter starts at 0 on grant, so the last allowed waiting cycle is
    // TIMEOUT-1; bus_req is therefore high for exactly TIMEOUT cycles.
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);

    arb_state_e             state_q,     state_d;
    bus_cmd_t               cmd_q,       cmd_d;
    logic                   busReq_q,    busReq_d;
    logic [BURST_W-1:0]     burstCnt_q,  burstCnt_d;
    logic [TMO_W-1:0]       tmoCnt_q,    tmoCnt_d;
    logic                   ifAck_q,     ifAck_d;
    logic                   memAck_q,    memAck_d;
    logic                   busErr_q,    busErr_d;
    logic [REG_BUS_W-1:0]   ifRdata_q,   ifRdata_d;
    logic [REG_BUS_W-1:0]   memRdata_q,  memRdata_d;

    logic                   ifPending;
    logic                   grantMem;
    logic                   grantIf;
    logic                   timeoutHit;

    // Arbitration terms. A flush in IDLE hides the fetch request for that
    // one cycle. MEM wins a tie unless it has already used its burst
    // allowance while IF was waiting.
    always_comb begin
        ifPending  = if_req & ~flush_in;
        grantMem   = mem_req & (~ifPending | (burstCnt_q != BURST_MAX));
        grantIf    = ifPending & ~grantMem;
        timeoutHit = (tmoCnt_q == TMO_LAST);
    end

    // Next-state logic. Acks and bus_err default to 0 so they only ever last
    // one cycle; captured read data is held until the next matching ack.
    // Within an access, bus_ack takes precedence over a timeout.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        busReq_d   = busReq_q;
        burstCnt_d = burstCnt_q;
        tmoCnt_d   = tmoCnt_q;
        ifAck_d    = 1'b0;
        memAck_d   = 1'b0;
        busErr_d   = 1'b0;
        ifRdata_d  = ifRdata_q;
        memRdata_d = memRdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grantMem) begin
                    cmd_d.we    = mem_we;
                    cmd_d.sel   = mem_sel;
                    cmd_d.addr  = mem_addr;
                    cmd_d.wdata = mem_wdata;
                    busReq_d    = 1'b1;
                    tmoCnt_d    = '0;
                    burstCnt_d  = ifPending ? burstCnt_q + BURST_W'(1) : '0;
                    state_d     = ARB_MEM_ACC;
                end else if (grantIf) begin
                    cmd_d      = fetchCmd(if_addr);
                    busReq_d   = 1'b1;
                    tmoCnt_d   = '0;
                    burstCnt_d = '0;
                    state_d    = ARB_IF_ACC;
                end
            end

            // A flush arriving together with bus_ack or the timeout finishes
            // the access right here, just without the fetch ack.
            ARB_IF_ACC: begin
                if (bus_ack) begin
                    busReq_d = 1'b0;
                    state_d  = ARB_IDLE;
                    if (!flush_in) begin
                        ifAck_d   = 1'b1;
                        ifRdata_d = bus_rdata;
                    end
                end else if (timeoutHit) begin
                    busReq_d = 1'b0;
                    busErr_d = 1'b1;
                    state_d  = ARB_IDLE;
                    if (!flush_in) begin
                        ifAck_d   = 1'b1;
                        ifRdata_d = '0;
                    end
                end else begin
                    tmoCnt_d = tmoCnt_q + TMO_W'(1);
                    if (flush_in) begin
                        state_d = ARB_IF_DRAIN;
                    end
                end
            end

            ARB_MEM_ACC: begin
                if (bus_ack) begin
                    busReq_d   = 1'b0;
                    memAck_d   = 1'b1;
                    memRdata_d = loadData(cmd_q.we, bus_rdata);
                    state_d    = ARB_IDLE;
                end else if (timeoutHit) begin
                    busReq_d   = 1'b0;
                    busErr_d   = 1'b1;
                    memAck_d   = 1'b1;
                    memRdata_d = '0;
                    state_d    = ARB_IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + TMO_W'(1);
                end
            end

            // The bus cycle of a flushed fetch must still complete; its data
            // is thrown away and only a timeout is reported.
            ARB_IF_DRAIN: begin
                if (bus_ack) begin
                    busReq_d = 1'b0;
                    state_d  = ARB_IDLE;
                end else if (timeoutHit) begin
                    busReq_d = 1'b0;
                    busErr_d = 1'b1;
                    state_d  = ARB_IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + TMO_W'(1);
                end
            end

            default: begin
                busReq_d = 1'b0;
                state_d  = ARB_IDLE;
            end
        endcase
    end

    // State and output registers. The reset is asynchronous so an access in
    // flight is abandoned immediately and bus_req falls without waiting for
    // a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            cmd_q      <= '0;
            busReq_q   <= 1'b0;
            burstCnt_q <= '0;
            tmoCnt_q   <= '0;
            ifAck_q    <= 1'b0;
            memAck_q   <= 1'b0;
            busErr_q   <= 1'b0;
            ifRdata_q  <= '0;
            memRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            busReq_q   <= busReq_d;
            burstCnt_q <= burstCnt_d;
            tmoCnt_q   <= tmoCnt_d;
            ifAck_q    <= ifAck_d;
            memAck_q   <= memAck_d;
            busErr_q   <= busErr_d;
            ifRdata_q  <= ifRdata_d;
            memRdata_q <= memRdata_d;
        end
    end

    // Bus and completion outputs come straight from registers; the stall
    // requests are combinational so the pipeline is released in the ack cycle.
    assign bus_req       = busReq_q;
    assign bus_we        = cmd_q.we;
    assign bus_sel       = cmd_q.sel;
    assign bus_addr      = cmd_q.addr;
    assign bus_wdata     = cmd_q.wdata;
    assign bus_err       = busErr_q;
    assign if_ack        = ifAck_q;
    assign if_rdata      = ifRdata_q;
    assign mem_ack       = memAck_q;
    assign mem_rdata     = memRdata_q;
    assign stall_req_if  = if_req & ~ifAck_q;
    assign stall_req_mem = mem_req & ~memAck_q;

endmodule
